word_byte_serializer: RTL and testbench

Hardware transmit side of the byte-pair word stream: accepts 16-bit words on a valid/ready input, buffers them in a small FIFO, and emits each word as two bytes, MSB byte first, then LSB byte, on a valid/ready byte output. It sits between a word-producing datapath and a byte-wide sink such as a file-dump monitor or a UART. It is the exact inverse of the byte-pair reader that packs `hi lo` bytes into a 16-bit word.

---
 rtl/word_byte_serializer.sv | 135 +++++++++++++
 tb/tb_word_byte_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: buffers 16-bit words in a small FIFO and sends each
// one as two bytes on a valid/ready byte stream, MSB byte first.
module word_byte_serializer #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_byte,
    output logic          out_last,
    output logic [15:0]   words_sent,
    output logic [AW:0]   fifo_level
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    state_t         state;
    state_t         state_next;
    logic [15:0]    word;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           sent;

    // Fullness is judged on the registered level only, so a pop in the same
    // cycle never frees a slot early.
    assign in_ready = !rst && (fifo_level < FULL_LEVEL);
    assign push     = in_valid && in_ready;

    // Next state, FIFO pop request and byte outputs; outputs depend only on
    // the registered state and holding register.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        sent       = 1'b0;
        out_valid  = 1'b0;
        out_byte   = 8'h00;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    state_next = HI;
                end
            end
            HI: begin
                out_valid = 1'b1;
                out_byte  = word[15:8];
                if (out_ready) begin
                    state_next = LO;
                end
            end
            LO: begin
                out_valid = 1'b1;
                out_byte  = word[7:0];
                out_last  = 1'b1;
                if (out_ready) begin
                    sent = 1'b1;
                    if (fifo_level != '0) begin
                        pop        = 1'b1;
                        state_next = HI;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Holding register loaded from the FIFO head on every pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= 16'h0000;
        end else if (pop) begin
            word <= mem[rd_ptr];
        end
    end

    // FIFO storage; contents need no reset because the level gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers wrap naturally; the explicit level separates full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Count of words whose LSB byte has been taken by the sink.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_sent <= 16'h0000;
        end else if (sent) begin
            words_sent <= words_sent + 16'h0001;
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer: directed stimulus with a byte scoreboard queue
// filled on word acceptance and drained by an independent output monitor.
module tb_word_byte_serializer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [15:0] words_sent;
    logic [2:0]  fifo_level;

    logic [8:0]  exp_q [$];
    int          n_compared;
    int          n_mismatched;
    int          max_level;
    int          accepted;
    logic        prev_stalled;
    logic [8:0]  prev_out;

    word_byte_serializer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .words_sent (words_sent),
        .fifo_level (fifo_level)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait is never satisfied.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [15:0] w);
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({1'b1, w[7:0]});
    endtask

    // Output monitor: pops an expected byte on every accepted transfer and
    // checks that a stalled byte holds until the sink takes it.
    initial begin
        prev_stalled = 1'b0;
        prev_out     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stalled = 1'b0;
            end else begin
                if (prev_stalled) begin
                    check_output("stall_valid", 32'(out_valid), 32'd1);
                    check_output("stall_hold", 32'({out_last, out_byte}), 32'(prev_out));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_output("spurious_byte", 32'({out_last, out_byte}), 32'h1FF);
                    end else begin
                        check_output("byte", 32'({out_last, out_byte}), 32'(exp_q.pop_front()));
                    end
                end
                prev_stalled = out_valid && !out_ready;
                prev_out     = {out_last, out_byte};
            end
        end
    end

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_output("in_ready_during_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_byte", 32'(out_byte), 32'h00);
        check_output("rst_out_last", 32'(out_last), 32'd0);
        check_output("rst_words_sent", 32'(words_sent), 32'd0);
        check_output("rst_fifo_level", 32'(fifo_level), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Offers one word and returns 1 ns after the edge that accepted it.
    task automatic apply_stimulus(input logic [15:0] w);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
        end
        if (got) begin
            push_expected(w);
        end else begin
            check_output("accept_timeout", 32'd0, 32'd1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    // Holds in_valid high over consecutive words base, base+1, ...
    task automatic push_stream(input logic [15:0] base, input int count, input int max_cycles, output int acc);
        int  idx;
        int  cyc;
        bit  go;
        idx = 0;
        cyc = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = base;
        while (idx < count && cyc < max_cycles) begin
            @(negedge clk);
            go = in_ready;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            @(posedge clk);
            cyc++;
            if (go) begin
                push_expected(base + 16'(idx));
                idx++;
            end
            #1;
            in_data = base + 16'(idx);
        end
        in_valid = 1'b0;
        acc = idx;
    endtask

    task automatic wait_words(input logic [15:0] target, input int limit);
        for (int c = 0; c < limit && words_sent != target; c++) begin
            @(negedge clk);
        end
        check_output("words_sent", 32'(words_sent), 32'(target));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        max_level    = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 16'h0000;
        out_ready    = 1'b0;

        // Single word: latency and byte order.
        reset_dut();
        out_ready = 1'b1;
        apply_stimulus(16'h1234);
        @(negedge clk);
        check_output("single_level", 32'(fifo_level), 32'd1);
        check_output("single_no_bypass", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_output("single_hi_valid", 32'(out_valid), 32'd1);
        check_output("single_hi_byte", 32'({out_last, out_byte}), 32'h012);
        @(negedge clk);
        check_output("single_lo_byte", 32'({out_last, out_byte}), 32'h134);
        @(negedge clk);
        check_output("single_idle", 32'(out_valid), 32'd0);
        check_output("single_sent", 32'(words_sent), 32'd1);

        // Overfill: capacity is FIFO depth plus the holding register.
        reset_dut();
        out_ready = 1'b0;
        push_stream(16'hA000, 6, 8, accepted);
        check_output("overfill_accepted", 32'(accepted), 32'd5);
        @(negedge clk);
        check_output("overfill_in_ready", 32'(in_ready), 32'd0);
        check_output("overfill_level", 32'(fifo_level), 32'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_output("overfill_no_bubble", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        check_output("overfill_sent", 32'(words_sent), 32'd5);
        check_output("overfill_drained", 32'(out_valid), 32'd0);

        // Backpressure: out_ready alternates every cycle.
        reset_dut();
        out_ready = 1'b0;
        apply_stimulus(16'hBEEF);
        apply_stimulus(16'hCAFE);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        wait_words(16'd2, 20);

        // Pointer wrap with continuous input.
        reset_dut();
        out_ready = 1'b1;
        max_level = 0;
        push_stream(16'h0000, 20, 100, accepted);
        check_output("wrap_accepted", 32'(accepted), 32'd20);
        wait_words(16'd20, 100);
        check_output("wrap_max_level_ok", 32'(max_level <= 4), 32'd1);
        check_output("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a word.
        reset_dut();
        out_ready = 1'b0;
        apply_stimulus(16'hABCD);
        apply_stimulus(16'h1111);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_level", 32'(fifo_level), 32'd0);
        check_output("midrst_sent", 32'(words_sent), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 6; k++) @(negedge clk);
        check_output("midrst_quiet", 32'(out_valid), 32'd0);

        // Full FIFO while the LO byte is popped: no push that cycle.
        reset_dut();
        out_ready = 1'b0;
        push_stream(16'hC000, 5, 20, accepted);
        in_valid  = 1'b1;
        in_data   = 16'hC005;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("fullpop_in_ready", 32'(in_ready), 32'd0);
        check_output("fullpop_level4", 32'(fifo_level), 32'd4);
        check_output("fullpop_in_lo", 32'(out_last), 32'd1);
        @(negedge clk);
        check_output("fullpop_level3", 32'(fifo_level), 32'd3);
        check_output("fullpop_ready_again", 32'(in_ready), 32'd1);
        @(posedge clk);
        push_expected(16'hC005);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_output("fullpop_refill", 32'(fifo_level), 32'd4);
        wait_words(16'd6, 40);
        check_output("fullpop_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
